// File: rtl/div_unit.sv
// Signed sequential divider for the HI/LO path: restoring shift-subtract, one quotient bit per cycle.
// LO_Out = quotient, HI_Out = remainder (sign follows the dividend); all state moves on the falling clock edge.
//
// state | meaning
// IDLE  | waiting for a rising Div_Control sample
// INIT  | divide-by-zero check, take magnitudes and result signs
// RUN   | WIDTH shift-subtract iterations
// FIX   | apply signs, publish result, pulse Div_Done
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Div_Control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI_Out,
  output logic [WIDTH-1:0] LO_Out,
  output logic             Div_Busy,
  output logic             Div_Done,
  output logic             Div_Zero
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state, state_nx;
  logic               ctl_prev;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [WIDTH-1:0]   dvd, dvs;
  logic [WIDTH:0]     acc;
  logic [CNT_W-1:0]   cnt;
  logic               sq, sr, dz;

  logic               start;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     acc_sh, acc_nx;
  logic               ge;

  assign start = (state == IDLE) && Div_Control && !ctl_prev;

  // The most negative dividend wraps to 2**(WIDTH-1), which is the correct unsigned magnitude.
  assign a_abs = a_reg[WIDTH-1] ? -a_reg : a_reg;
  assign b_abs = b_reg[WIDTH-1] ? -b_reg : b_reg;

  assign acc_sh = {acc[WIDTH-1:0], dvd[WIDTH-1]};
  assign ge     = acc_sh >= {1'b0, dvs};
  assign acc_nx = ge ? (acc_sh - {1'b0, dvs}) : acc_sh;

  always_ff @(negedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = INIT;
      INIT: state_nx = (b_reg == '0) ? FIX : RUN;
      RUN:  if (cnt == LAST_CNT) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(negedge Clock or negedge Reset) begin
    if (!Reset) begin
      ctl_prev <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      dvd      <= '0;
      dvs      <= '0;
      acc      <= '0;
      cnt      <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      dz       <= 1'b0;
      HI_Out   <= '0;
      LO_Out   <= '0;
      Div_Busy <= 1'b0;
      Div_Done <= 1'b0;
      Div_Zero <= 1'b0;
    end else begin
      ctl_prev <= Div_Control;
      Div_Done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= A;
            b_reg    <= B;
            Div_Busy <= 1'b1;
          end
        end
        INIT: begin
          Div_Zero <= (b_reg == '0);
          dz       <= (b_reg == '0);
          dvd      <= a_abs;
          dvs      <= b_abs;
          sq       <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          sr       <= a_reg[WIDTH-1];
          acc      <= '0;
          cnt      <= '0;
        end
        RUN: begin
          acc <= acc_nx;
          dvd <= {dvd[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          // A zero divisor still passes through here so its Done pulse lands two edges after start.
          if (!dz) begin
            LO_Out <= sq ? -dvd : dvd;
            HI_Out <= sr ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
          end
          Div_Done <= 1'b1;
          Div_Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotients/remainders, latency, div-by-zero,
// start-edge filtering and asynchronous abort.
module tb_div_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Div_Control = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] HI_Out, LO_Out;
  logic        Div_Busy, Div_Done, Div_Zero;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int dones;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock(Clock), .Reset(Reset), .Div_Control(Div_Control), .A(A), .B(B),
    .HI_Out(HI_Out), .LO_Out(LO_Out), .Div_Busy(Div_Busy), .Div_Done(Div_Done),
    .Div_Zero(Div_Zero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Launch a division and return the number of falling edges from the start edge to Div_Done.
  task automatic run_div(input logic [31:0] a_v, input logic [31:0] b_v, output int edges);
    A = a_v;
    B = b_v;
    Div_Control = 1'b1;
    @(negedge Clock); #1;
    check("busy_after_start", {31'd0, Div_Busy}, 32'd1);
    edges = 100;
    for (int k = 1; k <= 100; k++) begin
      @(negedge Clock); #1;
      if (Div_Done) begin
        edges = k;
        break;
      end
    end
    check("busy_low_at_done", {31'd0, Div_Busy}, 32'd0);
    Div_Control = 1'b0;
    @(negedge Clock); #1;
    check("done_one_cycle", {31'd0, Div_Done}, 32'd0);
  endtask

  initial begin
    #22 Reset = 1'b1;
    @(negedge Clock); #1;
    check("rst_hi", HI_Out, 32'd0);
    check("rst_lo", LO_Out, 32'd0);
    check("rst_busy", {31'd0, Div_Busy}, 32'd0);
    check("rst_done", {31'd0, Div_Done}, 32'd0);
    check("rst_zero", {31'd0, Div_Zero}, 32'd0);

    run_div(32'd7, 32'd2, lat);
    check("p7d2_lat", lat, 32'd34);
    check("p7d2_lo", LO_Out, 32'd3);
    check("p7d2_hi", HI_Out, 32'd1);
    check("p7d2_zero", {31'd0, Div_Zero}, 32'd0);

    run_div(32'hFFFF_FFF9, 32'd2, lat);
    check("m7d2_lo", LO_Out, 32'hFFFF_FFFD);
    check("m7d2_hi", HI_Out, 32'hFFFF_FFFF);

    run_div(32'd7, 32'hFFFF_FFFE, lat);
    check("p7dm2_lo", LO_Out, 32'hFFFF_FFFD);
    check("p7dm2_hi", HI_Out, 32'd1);

    run_div(32'd100, 32'd0, lat);
    check("dz_lat", lat, 32'd2);
    check("dz_flag", {31'd0, Div_Zero}, 32'd1);
    check("dz_lo_kept", LO_Out, 32'hFFFF_FFFD);
    check("dz_hi_kept", HI_Out, 32'd1);

    run_div(32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("ovf_lo", LO_Out, 32'h8000_0000);
    check("ovf_hi", HI_Out, 32'd0);
    check("ovf_zero_clr", {31'd0, Div_Zero}, 32'd0);

    run_div(32'h8000_0000, 32'd1, lat);
    check("minby1_lo", LO_Out, 32'h8000_0000);
    check("minby1_hi", HI_Out, 32'd0);

    run_div(32'd1000, 32'd7, lat);
    check("p1000d7_lo", LO_Out, 32'd142);
    check("p1000d7_hi", HI_Out, 32'd6);

    // -1000 / -7 = 142 remainder -6
    run_div(32'hFFFF_FC18, 32'hFFFF_FFF9, lat);
    check("m1000dm7_lo", LO_Out, 32'd142);
    check("m1000dm7_hi", HI_Out, 32'hFFFF_FFFA);

    // Held-high start plus a re-pulse during busy: exactly one division.
    A = 32'd50;
    B = 32'd5;
    Div_Control = 1'b1;
    @(negedge Clock); #1;
    dones = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge Clock); #1;
      if (Div_Done) dones++;
      if (i == 5) Div_Control = 1'b0;
      if (i == 7) Div_Control = 1'b1;
    end
    check("held_done_count", dones, 32'd1);
    check("held_lo", LO_Out, 32'd10);
    Div_Control = 1'b0;
    @(negedge Clock); #1;

    // Abort in the middle of RUN.
    A = 32'd1000;
    B = 32'd3;
    Div_Control = 1'b1;
    @(negedge Clock); #1;
    repeat (11) @(negedge Clock);
    #1;
    check("abort_busy_before", {31'd0, Div_Busy}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("abort_hi", HI_Out, 32'd0);
    check("abort_lo", LO_Out, 32'd0);
    check("abort_busy", {31'd0, Div_Busy}, 32'd0);
    Div_Control = 1'b0;
    @(negedge Clock); #1;
    Reset = 1'b1;
    dones = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge Clock); #1;
      if (Div_Done) dones++;
    end
    check("abort_no_done", dones, 32'd0);

    run_div(32'd9, 32'd3, lat);
    check("after_abort_lat", lat, 32'd34);
    check("after_abort_lo", LO_Out, 32'd3);
    check("after_abort_hi", HI_Out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
